// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state TMS decoder, 4-bit instruction register,
// IDCODE/BYPASS data registers and the falling-edge TDO multiplexer.
module jtag_tap_ctrl #(
    parameter int unsigned IR_LEN     = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1180_0001
) (
    input  logic tck_i,
    input  logic trst_ni,
    input  logic tms_i,
    input  logic tdi_i,
    input  logic bs_chain_tdo_i,
    input  logic mbist_tdo_i,
    input  logic debug_tdo_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic extest_select_o,
    output logic sample_preload_select_o,
    output logic mbist_select_o,
    output logic debug_select_o
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } state_e;

    localparam logic [IR_LEN-1:0] OP_EXTEST  = IR_LEN'(4'b0000);
    localparam logic [IR_LEN-1:0] OP_IDCODE  = IR_LEN'(4'b0001);
    localparam logic [IR_LEN-1:0] OP_SAMPLE  = IR_LEN'(4'b0010);
    localparam logic [IR_LEN-1:0] OP_MBIST   = IR_LEN'(4'b1000);
    localparam logic [IR_LEN-1:0] OP_DEBUG   = IR_LEN'(4'b1001);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(4'b0101);

    state_e              state_q, state_d;
    logic [IR_LEN-1:0]   ir_q, ir_d;
    logic [IR_LEN-1:0]   ir_sr_q, ir_sr_d;
    logic [31:0]         idcode_sr_q, idcode_sr_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdo_oe_q, tdo_oe_d;

    logic is_extest, is_sample, is_mbist, is_debug, is_idcode, is_bypass;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms_i ? TLR    : RTI;
            RTI:    state_d = tms_i ? SEL_DR : RTI;
            SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms_i ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms_i ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms_i ? SEL_DR : RTI;
            SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms_i ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms_i ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms_i ? SEL_DR : RTI;
        endcase
    end

    // Raw opcode decode; anything unrecognised falls through to BYPASS.
    always_comb begin
        is_extest = (ir_q == OP_EXTEST);
        is_sample = (ir_q == OP_SAMPLE);
        is_mbist  = (ir_q == OP_MBIST);
        is_debug  = (ir_q == OP_DEBUG);
        is_idcode = (ir_q == OP_IDCODE);
        is_bypass = !(is_extest || is_sample || is_mbist || is_debug || is_idcode);
    end

    always_comb begin
        ir_sr_d     = ir_sr_q;
        ir_d        = ir_q;
        idcode_sr_d = idcode_sr_q;
        bypass_d    = bypass_q;

        if (state_q == CAP_IR)
            ir_sr_d = IR_CAPTURE;
        else if (state_q == SH_IR)
            ir_sr_d = {tdi_i, ir_sr_q[IR_LEN-1:1]};

        if (state_q == TLR)
            ir_d = OP_IDCODE;
        else if (state_q == UPD_IR)
            ir_d = ir_sr_q;

        if (state_q == CAP_DR) begin
            idcode_sr_d = IDCODE_VAL;
            bypass_d    = 1'b0;
        end else if (state_q == SH_DR) begin
            if (is_idcode) idcode_sr_d = {tdi_i, idcode_sr_q[31:1]};
            if (is_bypass) bypass_d    = tdi_i;
        end
    end

    always_comb begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
        if (state_q == SH_IR) begin
            tdo_oe_d = 1'b1;
            tdo_d    = ir_sr_q[0];
        end else if (state_q == SH_DR) begin
            tdo_oe_d = 1'b1;
            if (is_extest || is_sample) tdo_d = bs_chain_tdo_i;
            else if (is_mbist)          tdo_d = mbist_tdo_i;
            else if (is_debug)          tdo_d = debug_tdo_i;
            else if (is_idcode)         tdo_d = idcode_sr_q[0];
            else                        tdo_d = bypass_q;
        end
    end

    always_comb begin
        test_logic_reset_o      = (state_q == TLR);
        capture_dr_o            = (state_q == CAP_DR);
        shift_dr_o              = (state_q == SH_DR);
        pause_dr_o              = (state_q == PAU_DR);
        update_dr_o             = (state_q == UPD_DR);
        extest_select_o         = (state_q != TLR) && is_extest;
        sample_preload_select_o = (state_q != TLR) && is_sample;
        mbist_select_o          = (state_q != TLR) && is_mbist;
        debug_select_o          = (state_q != TLR) && is_debug;
        tdo_o                   = tdo_q;
        tdo_oe_o                = tdo_oe_q;
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q     <= TLR;
            ir_q        <= OP_IDCODE;
            ir_sr_q     <= '0;
            idcode_sr_q <= IDCODE_VAL;
            bypass_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            idcode_sr_q <= idcode_sr_d;
            bypass_q    <= bypass_d;
        end
    end

    // TDO launches on the falling edge so the far end can sample on the rise.
    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

endmodule
